// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - IEEE 802.3 clause 22 MDIO management master
//
// Purpose: accepts one read/write request at a time on a valid/ready handshake
// and serialises it as a clause 22 frame: preamble, ST, OP, PHYAD, REGAD,
// TA and 16 data bits. Each bit is 2*CLK_DIV clk cycles: mdc low, then mdc high.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   s_valid/s_ready              request handshake (ready only while idle)
//   s_write, s_phy_addr,
//   s_reg_addr, s_wdata          request fields, captured at acceptance
//   rsp_valid                    one-cycle pulse at the end of each frame
//   rsp_rdata, rsp_err           read data (held until next read) / TA error
//   busy                         high from acceptance through rsp_valid
//   mdc                          management clock
//   mdio_o, mdio_t, mdio_i       serial out, release (1 = tristate), serial in
module mdio_master #(
  parameter int CLK_DIV      = 25,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_write,
  input  logic [4:0]  s_phy_addr,
  input  logic [4:0]  s_reg_addr,
  input  logic [15:0] s_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam logic [8:0] HALF     = 9'(CLK_DIV);
  localparam logic [8:0] LAST     = 9'(2 * CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN == 0) ? 0 : PREAMBLE_LEN - 1);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_e;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;       // clk cycle within the current bit
  logic [5:0]  bit_q, bit_d;       // bit index within the current state
  logic [31:0] sh_q, sh_d;         // ST, OP, PHYAD, REGAD, TA, DATA; MSB goes out next
  logic        wr_q, wr_d;
  logic        rx_q;               // mdio_i registered once
  logic [15:0] rx_sh_q, rx_sh_d;
  logic        ta_q, ta_d;         // sampled second TA bit
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mdc_q, mdc_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_t_q, mdio_t_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      wr_q     <= 1'b0;
      rx_q     <= 1'b1;
      rx_sh_q  <= '0;
      ta_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mdc_q    <= 1'b0;
      mdio_o_q <= 1'b1;
      mdio_t_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      wr_q     <= wr_d;
      rx_q     <= mdio_i;
      rx_sh_q  <= rx_sh_d;
      ta_q     <= ta_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      mdc_q    <= mdc_d;
      mdio_o_q <= mdio_o_d;
      mdio_t_q <= mdio_t_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    wr_d     = wr_q;
    rx_sh_d  = rx_sh_q;
    ta_d     = ta_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mdio_o_d = mdio_o_q;
    mdio_t_d = mdio_t_q;

    case (state_q)
      IDLE: begin
        mdio_o_d = 1'b1;
        mdio_t_d = 1'b1;
        cnt_d    = '0;
        bit_d    = '0;
        if (s_valid) begin
          wr_d  = s_write;
          sh_d  = {2'b01, (s_write ? 2'b01 : 2'b10), s_phy_addr, s_reg_addr, 2'b10, s_wdata};
          // mdc is already low here, so the acceptance cycle serves as the
          // first low-phase cycle of bit 0; the divider restarts at 1.
          cnt_d    = 9'd1;
          err_d    = 1'b0;
          mdio_t_d = 1'b0;
          state_d  = (PREAMBLE_LEN == 0) ? HDR : PRE;
          mdio_o_d = (PREAMBLE_LEN != 0);   // preamble '1' or ST '0'
        end
      end
      PRE, HDR, TA, DATA: begin
        cnt_d = cnt_q + 9'd1;
        // First cycle of mdc high: sample the registered line.
        if (cnt_q == HALF) begin
          if (state_q == TA && bit_q == 6'd1) ta_d = rx_q;
          if (state_q == DATA) rx_sh_d = {rx_sh_q[14:0], rx_q};
        end
        if (cnt_q == LAST) begin
          cnt_d = '0;
          bit_d = bit_q + 6'd1;
          if (state_q != PRE) sh_d = {sh_q[30:0], 1'b0};
          case (state_q)
            PRE:  if (bit_q == PRE_LAST) begin state_d = HDR;  bit_d = '0; end
            HDR:  if (bit_q == 6'd13)    begin state_d = TA;   bit_d = '0; end
            TA:   if (bit_q == 6'd1)     begin state_d = DATA; bit_d = '0; end
            DATA: if (bit_q == 6'd15)    begin state_d = DONE; bit_d = '0; end
            default: ;
          endcase
          if (state_d == DONE) begin
            // Writes keep driving the last data bit through DONE.
            if (!wr_q) begin
              rdata_d = rx_sh_d;
              err_d   = ta_d;
            end else begin
              err_d   = 1'b0;
            end
          end else begin
            mdio_t_d = !wr_q && (state_d == TA || state_d == DATA);
            mdio_o_d = mdio_t_d || (state_d == PRE) || sh_d[31];
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        cnt_d    = '0;
        mdio_o_d = 1'b1;
        mdio_t_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    mdc_d = (state_d != IDLE) && (state_d != DONE) && (cnt_d >= HALF);
  end

  assign s_ready   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - directed bench for mdio_master
module tb_mdio_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid, s_write;
  logic [4:0]  s_phy_addr, s_reg_addr;
  logic [15:0] s_wdata;
  logic        s_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_t;
  logic [15:0] rsp_rdata;
  logic        mdio_i;

  logic        s_valid2, s_ready2, rsp_valid2, rsp_err2, busy2, mdc2, mdio_o2, mdio_t2;
  logic [15:0] rsp_rdata2;
  logic        mdio_i2;

  always #5 clk = ~clk;

  mdio_master dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_write(s_write), .s_phy_addr(s_phy_addr), .s_reg_addr(s_reg_addr),
    .s_wdata(s_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_t(mdio_t), .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_write(s_write), .s_phy_addr(s_phy_addr), .s_reg_addr(s_reg_addr),
    .s_wdata(s_wdata), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .rsp_err(rsp_err2), .busy(busy2), .mdc(mdc2), .mdio_o(mdio_o2),
    .mdio_t(mdio_t2), .mdio_i(mdio_i2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // PHY model and stimulus globals
  logic        phy_present;
  logic [15:0] phy_data;
  logic        hold;
  logic        nxt_wr;
  logic [4:0]  nxt_phy, nxt_reg;
  logic [15:0] nxt_wd;

  function automatic logic phy_bit(input int k);
    if (!phy_present) return 1'b1;
    if (k == 47) return 1'b0;
    if (k >= 48 && k <= 63) return phy_data[63 - k];
    return 1'b1;
  endfunction

  // Called at the negedge of the acceptance cycle; returns at the negedge
  // where rsp_valid is seen (or when the budget expires).
  task automatic collect(output logic [63:0] fo, output logic [63:0] ft, output int cyc,
                         output logic got, output logic [15:0] rd, output logic er,
                         output logic flags_ok);
    int   nb;
    logic pm;
    fo = '0; ft = '0; cyc = 0; got = 1'b0; rd = '0; er = 1'b0; flags_ok = 1'b1;
    nb = 0; pm = 1'b0;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      cyc = i;
      if (i == 1 && !hold) s_valid = 1'b0;
      if (i == 100) begin
        s_write = nxt_wr; s_phy_addr = nxt_phy; s_reg_addr = nxt_reg; s_wdata = nxt_wd;
      end
      if (!busy || s_ready) flags_ok = 1'b0;
      if (mdc && !pm) begin
        fo = {fo[62:0], mdio_o};
        ft = {ft[62:0], mdio_t};
        nb++;
      end
      if (!mdc && pm) mdio_i = phy_bit(nb);
      pm = mdc;
      if (rsp_valid) begin
        got = 1'b1; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    mdio_i = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic        present;
    logic [15:0] pdata;
    logic [63:0] exp_fo;
    logic [63:0] exp_ft;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  logic [63:0] fo, ft;
  int          cyc;
  logic        got, er, fl;
  logic [15:0] rd;

  initial begin
    vecs[0] = '{1'b1, 5'd7,  5'd0,  16'h1140, 1'b0, 16'h0000, 64'hFFFFFFFF_53821140, 64'h0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 5'd7,  5'd1,  16'h0000, 1'b1, 16'h796D, 64'hFFFFFFFF_6387FFFF, 64'h3FFFF, 16'h796D, 1'b0};
    vecs[2] = '{1'b0, 5'd3,  5'd2,  16'h0000, 1'b0, 16'h0000, 64'hFFFFFFFF_618BFFFF, 64'h3FFFF, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b1, 5'd31, 5'd31, 16'hA5C3, 1'b0, 16'h0000, 64'hFFFFFFFF_5FFEA5C3, 64'h0, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  5'd0,  16'h0000, 1'b1, 16'h0001, 64'hFFFFFFFF_6003FFFF, 64'h3FFFF, 16'h0001, 1'b0};

    reset_n = 1'b0; s_valid = 1'b0; s_valid2 = 1'b0; s_write = 1'b0;
    s_phy_addr = '0; s_reg_addr = '0; s_wdata = '0; mdio_i = 1'b1; mdio_i2 = 1'b1;
    phy_present = 1'b0; phy_data = '0; hold = 1'b0;
    nxt_wr = 1'b0; nxt_phy = '0; nxt_reg = '0; nxt_wd = '0;

    repeat (3) @(negedge clk);
    chk("rst_mdc", mdc, 0);
    chk("rst_mdio_t", mdio_t, 1);
    chk("rst_mdio_o", mdio_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);

    // Suppressed preamble, fast divider: 32-bit frame
    begin
      logic [31:0] f2;
      int nb2, r1, r2, c2;
      logic pm2, g2;
      f2 = '0; nb2 = 0; r1 = -1; r2 = -1; c2 = 0; pm2 = 1'b0; g2 = 1'b0;
      s_write = 1'b1; s_phy_addr = 5'd7; s_reg_addr = 5'd0; s_wdata = 16'h1140; s_valid2 = 1'b1;
      for (int i = 1; i <= 400; i++) begin
        @(negedge clk);
        c2 = i;
        if (i == 1) s_valid2 = 1'b0;
        if (mdc2 && !pm2) begin
          f2 = {f2[30:0], mdio_o2};
          nb2++;
          if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
        end
        pm2 = mdc2;
        if (rsp_valid2) begin g2 = 1'b1; break; end
      end
      chk("p0_rsp_seen", g2, 1);
      chk("p0_rsp_cycle", c2, 128);
      chk("p0_frame", f2, 32'h53821140);
      chk("p0_bits", nb2, 32);
      chk("p0_mdc_period", r2 - r1, 4);
    end

    // Table-driven frames on the default instance
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      s_write = vecs[v].wr; s_phy_addr = vecs[v].phy; s_reg_addr = vecs[v].rg; s_wdata = vecs[v].wd;
      nxt_wr = ~vecs[v].wr; nxt_phy = ~vecs[v].phy; nxt_reg = ~vecs[v].rg; nxt_wd = ~vecs[v].wd;
      phy_present = vecs[v].present; phy_data = vecs[v].pdata; hold = 1'b0;
      s_valid = 1'b1;
      collect(fo, ft, cyc, got, rd, er, fl);
      chk($sformatf("v%0d_rsp_seen", v), got, 1);
      chk($sformatf("v%0d_rsp_cycle", v), cyc, 3200);
      chk($sformatf("v%0d_mdio_o", v), fo, vecs[v].exp_fo);
      chk($sformatf("v%0d_mdio_t", v), ft, vecs[v].exp_ft);
      chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
      chk($sformatf("v%0d_err", v), er, vecs[v].exp_err);
      chk($sformatf("v%0d_busy_ready", v), fl, 1);
    end

    // Back-to-back with s_valid held; fields change mid-frame 1
    @(negedge clk);
    phy_present = 1'b0; hold = 1'b1;
    s_write = 1'b1; s_phy_addr = 5'd1; s_reg_addr = 5'd2; s_wdata = 16'hBEEF;
    nxt_wr = 1'b1; nxt_phy = 5'h15; nxt_reg = 5'h0A; nxt_wd = 16'h0F0F;
    s_valid = 1'b1;
    collect(fo, ft, cyc, got, rd, er, fl);
    chk("b2b1_rsp_cycle", cyc, 3200);
    chk("b2b1_frame", fo, 64'hFFFFFFFF_508ABEEF);
    chk("b2b1_busy_ready", fl, 1);
    @(negedge clk);
    chk("b2b_ready_after_done", s_ready, 1);
    chk("b2b_valid_still_high", s_valid, 1);
    hold = 1'b0; nxt_wr = 1'b0; nxt_phy = 5'd0; nxt_reg = 5'd0; nxt_wd = 16'h0;
    collect(fo, ft, cyc, got, rd, er, fl);
    chk("b2b2_rsp_cycle", cyc, 3200);
    chk("b2b2_frame", fo, 64'hFFFFFFFF_5AAA0F0F);

    // Reset asserted during HDR bit 5 of a read
    begin
      int   nb3;
      logic pm3, seen;
      nb3 = 0; pm3 = 1'b0; seen = 1'b0;
      @(negedge clk);
      s_write = 1'b0; s_phy_addr = 5'd7; s_reg_addr = 5'd1; s_valid = 1'b1;
      for (int i = 1; i <= 5000; i++) begin
        @(negedge clk);
        if (i == 1) s_valid = 1'b0;
        if (mdc && !pm3) nb3++;
        pm3 = mdc;
        if (nb3 == 38) break;
      end
      chk("rm_reached_hdr5", nb3, 38);
      chk("rm_mdc_high_before", mdc, 1);
      reset_n = 1'b0;
      #1;
      chk("rm_mdc", mdc, 0);
      chk("rm_mdio_t", mdio_t, 1);
      chk("rm_busy", busy, 0);
      chk("rm_rdata", rsp_rdata, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      chk("rm_no_rsp", seen, 0);
      chk("rm_ready", s_ready, 1);
    end
    @(negedge clk);
    s_write = 1'b0; s_phy_addr = 5'd7; s_reg_addr = 5'd1; s_wdata = 16'h0;
    nxt_wr = 1'b1; nxt_phy = 5'd0; nxt_reg = 5'd0; nxt_wd = 16'hFFFF;
    phy_present = 1'b1; phy_data = 16'h3C5A; hold = 1'b0;
    s_valid = 1'b1;
    collect(fo, ft, cyc, got, rd, er, fl);
    chk("ar_rsp_cycle", cyc, 3200);
    chk("ar_frame", fo, 64'hFFFFFFFF_6387FFFF);
    chk("ar_rdata", rd, 16'h3C5A);
    chk("ar_err", er, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25: clk cycles per MDC half-period (25 gives 2.5 MHz MDC at 125 MHz); legal range 2..255.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 32: number of preamble '1' bits per frame; legal range 0..32, where 0 means preamble suppressed.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1 bit: request valid.
REQ-006 SHALL have port s_ready, output, 1 bit: request accepted when s_valid and s_ready are both high.
REQ-007 SHALL have port s_write, input, 1 bit: 1 = write (OP 01), 0 = read (OP 10).
REQ-008 SHALL have port s_phy_addr, input, 5 bits: PHY address.
REQ-009 SHALL have port s_reg_addr, input, 5 bits: register address.
REQ-010 SHALL have port s_wdata, input, 16 bits: write data.
REQ-011 SHALL have port rsp_valid, output, 1 bit: one-cycle pulse at transaction end.
REQ-012 SHALL have port rsp_rdata, output, 16 bits: read data; held until the next read completes.
REQ-013 SHALL have port rsp_err, output, 1 bit: read turnaround error; valid while rsp_valid is high.
REQ-014 SHALL have port busy, output, 1 bit: high from acceptance through the rsp_valid cycle.
REQ-015 SHALL have port mdc, output, 1 bit: management clock.
REQ-016 SHALL have port mdio_o, output, 1 bit: serial data out.
REQ-017 SHALL have port mdio_t, output, 1 bit: 1 = release the line (tristate).
REQ-018 SHALL have port mdio_i, input, 1 bit: serial data in.

Function
REQ-019 SHALL implement states IDLE, PRE, HDR, TA, DATA, DONE; s_ready SHALL be 1 only in IDLE.
REQ-020 SHALL capture s_write, s_phy_addr, s_reg_addr and s_wdata at acceptance; later input changes SHALL not affect the frame in progress.
REQ-021 SHALL go from IDLE to PRE on acceptance, or directly to HDR when PREAMBLE_LEN=0.
REQ-022 SHALL send in HDR the 14 bits ST=01, OP, PHYAD, REGAD, MSB first.
REQ-023 SHALL send 2 bits in TA, then 16 bits in DATA (MSB first), then enter DONE.
REQ-024 SHALL hold DONE for one cycle (rsp_valid=1), then return to IDLE.
REQ-025 SHALL make each bit 2*CLK_DIV clk cycles: mdc low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-026 SHALL update mdio_o in the cycle mdc falls, and for the first bit in the cycle after acceptance.
REQ-027 SHALL hold mdc at 0 in IDLE and DONE; the divider SHALL clear on acceptance.
REQ-028 SHALL drive, on write, mdio_t=0 for all bits, with TA = '1','0' and DATA = captured s_wdata.
REQ-029 SHALL drive, on read, mdio_t=0 through HDR and mdio_t=1 from the start of TA through DONE.
REQ-030 SHALL register mdio_i once, and sample the registered value in the cycle mdc rises during TA bit 2 and each DATA bit.
REQ-031 SHALL set rsp_err=1 on a read if the sampled TA bit 2 is 1 (no PHY); rsp_rdata SHALL still load the 16 sampled bits.
REQ-032 SHALL force rsp_err=0 on writes and leave rsp_rdata unchanged.
REQ-033 SHALL assert rsp_valid exactly (PREAMBLE_LEN+32)*2*CLK_DIV cycles after the acceptance cycle.
REQ-034 SHALL keep mdio_t=1 in IDLE and mdio_o=1 whenever mdio_t=1.
REQ-035 SHALL allow back-to-back transfers: with s_valid held high, the next request SHALL be accepted the cycle after DONE; frames SHALL never overlap.
REQ-036 SHALL ignore s_valid while not in IDLE, with no queueing.
REQ-037 SHALL use a bit counter of 6 bits, wide enough for 32 preamble bits; counters SHALL not wrap inside a state.

Reset
REQ-038 SHALL, when reset_n is low, asynchronously clear: state=IDLE, mdc=0, mdio_t=1, mdio_o=1, s_ready=1 after release, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, all counters 0.
REQ-039 SHALL, on reset mid-frame, abort the frame with no rsp_valid; the first request after reset_n returns high SHALL produce a complete, normal frame.

Verification
REQ-040 Default params, write PHY 7, reg 0, data 0x1140 -> mdio_o sequence 32x'1', 01 01 00111 00000 10 0001000101000000; mdio_t=0 throughout; rsp_valid at cycle 3200; rsp_err=0.
REQ-041 Default params, read PHY 7, reg 1; PHY model drives TA bit 2 = 0, then 0x796D -> rsp_rdata=0x796D, rsp_err=0; mdio_t=1 from bit 46 onward.
REQ-042 Read with mdio_i pulled high (no PHY) -> rsp_err=1, rsp_rdata=0xFFFF.
REQ-043 PREAMBLE_LEN=0, CLK_DIV=2, write -> 32-bit frame; rsp_valid at cycle 128; mdc period 4 cycles.
REQ-044 s_valid held high for 2 requests -> second accepted the cycle after the first rsp_valid; s_ready=0 during frames; second request's fields changed mid-frame-1 are used only for frame 2.
REQ-045 reset_n pulsed low at HDR bit 5 -> mdc=0 and mdio_t=1 immediately; no rsp_valid; next read completes correctly.
